// File: rtl/pwm_deadtime_gen.sv
// Complementary gate driver stage for one PWM channel.
// Inserts a programmable dead time on every edge and provides a latched fault shutdown.
module pwm_deadtime_gen #(
  parameter int unsigned DT_W = 8
) (
  input  logic            clk1,
  input  logic            i_rst,
  input  logic            i_pwm,
  input  logic            i_en,
  input  logic [DT_W-1:0] i_dt_rise,
  input  logic [DT_W-1:0] i_dt_fall,
  input  logic [1:0]      i_polarity,
  input  logic            i_fault,
  input  logic            i_fault_clr,
  output logic            o_hs,
  output logic            o_ls,
  output logic            o_fault,
  output logic [2:0]      o_state
);

  typedef enum logic [2:0] {
    ST_OFF     = 3'd0,
    ST_LS_ON   = 3'd1,
    ST_DT_RISE = 3'd2,
    ST_HS_ON   = 3'd3,
    ST_DT_FALL = 3'd4,
    ST_FAULT   = 3'd5
  } state_t;

  state_t            state, state_d;
  logic [DT_W-1:0]   cnt, cnt_d;
  logic              pwm_m, pwm_s;
  logic              hs_q, ls_q, fault_q;
  logic              hs_d, ls_d, fault_d;

  // Two-flop synchronizer for the PWM input, which may come from another clock domain
  always_ff @(posedge clk1 or posedge i_rst) begin
    if (i_rst) begin
      pwm_m <= 1'b0;
      pwm_s <= 1'b0;
    end else begin
      pwm_m <= i_pwm;
      pwm_s <= pwm_m;
    end
  end

  // State, dead-time counter and registered gate decodes
  always_ff @(posedge clk1 or posedge i_rst) begin
    if (i_rst) begin
      state   <= ST_OFF;
      cnt     <= '0;
      hs_q    <= 1'b0;
      ls_q    <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      hs_q    <= hs_d;
      ls_q    <= ls_d;
      fault_q <= fault_d;
    end
  end

  // Next-state logic: fault beats disable beats the normal edge/dead-time sequencing
  always_comb begin
    state_d = state;
    cnt_d   = cnt;
    if (i_fault) begin
      state_d = ST_FAULT;
    end else if (!i_en && state != ST_FAULT) begin
      state_d = ST_OFF;
    end else begin
      case (state)
        ST_OFF: begin
          if (pwm_s) begin
            state_d = ST_DT_RISE;
            cnt_d   = i_dt_rise;
          end else begin
            state_d = ST_LS_ON;
          end
        end
        ST_LS_ON: begin
          if (pwm_s) begin
            state_d = ST_DT_RISE;
            cnt_d   = i_dt_rise;
          end
        end
        ST_DT_RISE: begin
          // Cancel back to low-side: the high side never turned on, so no gap is owed
          if (!pwm_s)            state_d = ST_LS_ON;
          else if (cnt == '0)    state_d = ST_HS_ON;
          else                   cnt_d   = cnt - DT_W'(1);
        end
        ST_HS_ON: begin
          if (!pwm_s) begin
            state_d = ST_DT_FALL;
            cnt_d   = i_dt_fall;
          end
        end
        ST_DT_FALL: begin
          if (pwm_s)             state_d = ST_HS_ON;
          else if (cnt == '0)    state_d = ST_LS_ON;
          else                   cnt_d   = cnt - DT_W'(1);
        end
        ST_FAULT: begin
          if (i_fault_clr) state_d = ST_OFF;
        end
        default: state_d = ST_OFF;
      endcase
    end
    hs_d    = (state_d == ST_HS_ON);
    ls_d    = (state_d == ST_LS_ON);
    fault_d = (state_d == ST_FAULT);
  end

  assign o_hs    = hs_q ^ i_polarity[0];
  assign o_ls    = ls_q ^ i_polarity[1];
  assign o_fault = fault_q;
  assign o_state = state;

endmodule

// File: tb/tb_pwm_deadtime_gen.sv
// Directed bench for pwm_deadtime_gen: edge timing, dead-time gaps, cancel, fault latch, polarity, reset.
module tb_pwm_deadtime_gen;

  localparam int unsigned DT_W = 8;

  logic            clk1;
  logic            i_rst;
  logic            i_pwm;
  logic            i_en;
  logic [DT_W-1:0] i_dt_rise;
  logic [DT_W-1:0] i_dt_fall;
  logic [1:0]      i_polarity;
  logic            i_fault;
  logic            i_fault_clr;
  logic            o_hs;
  logic            o_ls;
  logic            o_fault;
  logic [2:0]      o_state;

  int n_cmp = 0;
  int n_err = 0;
  int overlap = 0;

  pwm_deadtime_gen #(.DT_W(DT_W)) dut (
    .clk1        (clk1),
    .i_rst       (i_rst),
    .i_pwm       (i_pwm),
    .i_en        (i_en),
    .i_dt_rise   (i_dt_rise),
    .i_dt_fall   (i_dt_fall),
    .i_polarity  (i_polarity),
    .i_fault     (i_fault),
    .i_fault_clr (i_fault_clr),
    .o_hs        (o_hs),
    .o_ls        (o_ls),
    .o_fault     (o_fault),
    .o_state     (o_state)
  );

  initial begin
    clk1 = 1'b0;
    forever #5 clk1 = ~clk1;
  end

  // Shoot-through monitor on the raw (polarity-removed) gate pair
  always @(negedge clk1) begin
    if ((o_hs ^ i_polarity[0]) && (o_ls ^ i_polarity[1])) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk1);
      #1;
    end
  endtask

  int gap;
  int ls_low;
  int hs_seen;

  initial begin
    i_rst = 1'b1; i_pwm = 1'b0; i_en = 1'b0;
    i_dt_rise = 8'd3; i_dt_fall = 8'd5;
    i_polarity = 2'b00; i_fault = 1'b0; i_fault_clr = 1'b0;
    tick(3);

    // Reset values
    check("rst_state", 32'(o_state), 32'd0);
    check("rst_hs", 32'(o_hs), 32'd0);
    check("rst_ls", 32'(o_ls), 32'd0);
    check("rst_fault", 32'(o_fault), 32'd0);
    i_polarity = 2'b11;
    #1;
    check("rst_pol_hs", 32'(o_hs), 32'd1);
    check("rst_pol_ls", 32'(o_ls), 32'd1);
    i_polarity = 2'b00;

    // Bring up into LS_ON
    i_rst = 1'b0; i_en = 1'b1;
    tick(4);
    check("up_state", 32'(o_state), 32'd1);
    check("up_ls", 32'(o_ls), 32'd1);

    // Rising edge: sync latency then dt_rise+1 = 4 cycle gap
    i_pwm = 1'b1;
    tick(2);
    check("rise_sync_ls", 32'(o_ls), 32'd1);
    tick(1);
    check("rise_ls_off", 32'(o_ls), 32'd0);
    check("rise_state", 32'(o_state), 32'd2);
    tick(3);
    check("rise_gap_hs", 32'(o_hs), 32'd0);
    tick(1);
    check("rise_hs_on", 32'(o_hs), 32'd1);
    check("hs_state", 32'(o_state), 32'd3);

    // Falling edge: dt_fall+1 = 6 cycle gap
    tick(5);
    i_pwm = 1'b0;
    tick(2);
    check("fall_sync_hs", 32'(o_hs), 32'd1);
    tick(1);
    check("fall_hs_off", 32'(o_hs), 32'd0);
    check("fall_state", 32'(o_state), 32'd4);
    tick(5);
    check("fall_gap_ls", 32'(o_ls), 32'd0);
    tick(1);
    check("fall_ls_on", 32'(o_ls), 32'd1);
    check("fall_end_state", 32'(o_state), 32'd1);

    // Zero dead time: exactly one both-off cycle per edge
    i_dt_rise = 8'd0; i_dt_fall = 8'd0;
    tick(3);
    for (int e = 0; e < 4; e++) begin
      i_pwm = ~i_pwm;
      gap = 0;
      for (int c = 0; c < 20; c++) begin
        tick(1);
        if (!o_hs && !o_ls) gap++;
      end
      check($sformatf("dt0_gap%0d", e), 32'(gap), 32'd1);
    end
    check("dt0_end_state", 32'(o_state), 32'd1);

    // Cancelled rise: short pulse aborts DT_RISE before the high side turns on
    i_dt_rise = 8'd10;
    i_pwm = 1'b1;
    ls_low = 0; hs_seen = 0;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      if (c == 2) begin
        check("cancel_in_dt", 32'(o_state), 32'd2);
        i_pwm = 1'b0;
      end
      if (!o_ls) ls_low++;
      if (o_hs) hs_seen++;
    end
    check("cancel_hs_never", 32'(hs_seen), 32'd0);
    check("cancel_ls_gap", 32'(ls_low), 32'd3);
    check("cancel_state", 32'(o_state), 32'd1);

    // Fault latch from HS_ON
    i_pwm = 1'b1;
    tick(20);
    check("pre_fault_state", 32'(o_state), 32'd3);
    i_fault = 1'b1;
    tick(1);
    i_fault = 1'b0;
    check("fault_state", 32'(o_state), 32'd5);
    check("fault_hs", 32'(o_hs), 32'd0);
    check("fault_ls", 32'(o_ls), 32'd0);
    check("fault_flag", 32'(o_fault), 32'd1);
    i_pwm = 1'b0;
    i_fault = 1'b1; i_fault_clr = 1'b1;
    tick(1);
    i_fault_clr = 1'b0;
    check("clr_ignored", 32'(o_state), 32'd5);
    i_fault = 1'b0;
    tick(3);
    check("fault_held", 32'(o_state), 32'd5);
    i_fault_clr = 1'b1;
    tick(1);
    i_fault_clr = 1'b0;
    check("clr_off", 32'(o_state), 32'd0);
    check("clr_flag", 32'(o_fault), 32'd0);
    tick(1);
    check("clr_ls_on", 32'(o_state), 32'd1);

    // Disabled with inverted polarity: both pads at 1
    i_polarity = 2'b11; i_en = 1'b0;
    tick(1);
    check("dis_state", 32'(o_state), 32'd0);
    check("pol_hs", 32'(o_hs), 32'd1);
    check("pol_ls", 32'(o_ls), 32'd1);

    // Asynchronous reset in the middle of DT_FALL
    i_polarity = 2'b00; i_en = 1'b1;
    i_dt_rise = 8'd0; i_dt_fall = 8'd5;
    i_pwm = 1'b1;
    tick(10);
    check("pre_rst_hs", 32'(o_state), 32'd3);
    i_pwm = 1'b0;
    tick(4);
    check("pre_rst_dtf", 32'(o_state), 32'd4);
    #2 i_rst = 1'b1;
    #1;
    check("async_rst_state", 32'(o_state), 32'd0);
    check("async_rst_hs", 32'(o_hs), 32'd0);
    check("async_rst_ls", 32'(o_ls), 32'd0);
    tick(2);

    check("no_overlap", 32'(overlap), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
